pwm_npc_multi: RTL
==================

# pwm_npc_multi

Multi-channel carrier PWM generator for the NPC inverter FPGA, the parametrised successor of the single-output PWM. One shared carrier counter drives CH channels. Each channel latches its duty word into a shadow register at the period boundary. The block adds a center-aligned mode, duty clamping, a period sync pulse, and complementary high/low gate outputs with programmable dead time. Outputs drive the gate-signal mapping logic for the NPC legs.

## Interface
- CH, 3: number of channels.
- W, 10: duty/counter width; W ≥ clog2(PERIOD+1).
- PERIOD, 1000: carrier top value, in clk cycles.
- DT, 8: dead time in clk cycles; 0 is legal.
- CENTER, 0: 0 = edge-aligned (sawtooth), 1 = center-aligned (triangle).

- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; when low, the counter is held and all gates are off.
- duty  in  CH*W  per-channel duty; channel k occupies bits [k*W +: W].
- s_hi  out  CH  high-side gate, per channel.
- s_lo  out  CH  low-side (complementary) gate, per channel.
- sync  out  1  one-cycle pulse when the counter is 0.
- cnt  out  W  current carrier count.

## Operation
- Reset: cnt=0, shadow=0, raw=0, s_hi=0, s_lo=0, sync=0, all channel FSMs in OFF.
- Edge mode: cnt runs 0,1,…,PERIOD-1,0. The period is PERIOD cycles.
- Center mode: cnt runs 0↑PERIOD, then PERIOD-1↓1, then 0. The period is 2*PERIOD cycles.
- Shadow load: on the clock edge that moves cnt to 0, shadow[k] ← min(duty[k], PERIOD). A duty change mid-period has no effect until that edge.
- Raw reference: raw[k] is registered as (shadow[k] > cnt).
- Consequences: duty=0 gives raw permanently 0; duty ≥ PERIOD gives raw permanently 1.
- en=0:
  - cnt is held at 0 and sync=0.
  - shadow[k] ← min(duty[k], PERIOD) every cycle.
  - All FSMs are forced to OFF.
- en 0→1: the counter starts from 0, and the first sync appears on the first enabled cycle.
- Dead-time FSM per channel, with a DT-cycle down-counter:
  - OFF: s_hi=0, s_lo=0. Leaves OFF on the first enabled cycle, to D2H if raw=1, else to D2L.
  - D2H: both gates 0; counts DT cycles, then goes to HI. If raw falls, go to D2L and restart the count.
  - HI: s_hi=1, s_lo=0. Goes to D2H→… never; on raw=0 goes to D2L.
  - D2L: both gates 0; counts DT cycles, then goes to LO. If raw rises, go to D2H and restart the count.
  - LO: s_hi=0, s_lo=1. On raw=1 goes to D2H.
  - DT=0: the dead states are skipped, so s_hi=raw and s_lo=~raw, except in OFF.
- Invariant: s_hi & s_lo is never 1 for any channel, in any cycle, including around reset.
- A raw pulse shorter than DT never reaches the far-side gate; the dead interval extends instead.

## Timing
- Output latency: raw lags cnt by 1 cycle; a gate lags raw by 1 cycle plus DT in dead states.
- A raw edge at cycle t makes the opposite gate active at t+1+DT.
- Edge mode, duty D with DT < D < PERIOD-DT:
  - s_hi is high D-DT cycles per period.
  - s_lo is high PERIOD-D-DT cycles per period.
- Asynchronous reset mid-period: all outputs drop immediately, with no dead sequencing.
- Reset release: outputs stay 0 until en is sampled high and the dead interval has elapsed.

## Structure
- Shared package pwm_pkg holds:
  - FSM state encoding (OFF, D2H, HI, D2L, LO);
  - the clog2 helper for the DT counter width;
  - the default PERIOD and DT constants.
- The top module holds the carrier counter, sync, the shadow registers and the raw comparators.
- Sub-module pwm_deadtime holds one channel's FSM and DT counter. It is instantiated CH times via generate.

## Test plan
- Reset mid-run (CH=3, duty=500 on all channels): pulse rst_n low at cnt=300 → all gates 0 in the same cycle. After release with en=1, cnt restarts at 0 and sync pulses every 1000 cycles.
- Edge mode, DT=8, duty0=500 → s_hi0 high 492 cycles and s_lo0 high 492 cycles per period, with 8-cycle gaps between them. The assertion s_hi&s_lo==0 holds throughout.
- duty0 changed 500→200 at cnt=400 → the current period still shows 492 high cycles; the next period shows 192.
- duty0=0 → s_hi0 never high and s_lo0 constant 1. duty0=1023 → clamped to 1000, s_hi0 constant 1, s_lo0 constant 0.
- duty0=5 with DT=8 → s_hi0 never asserts, and s_lo0 drops for 13 cycles each period.
- CENTER=1, PERIOD=1000, duty0=250, DT=0 → sync period 2000 cycles and raw high 499 cycles centred on cnt=0. The shadow updates only at cnt=0.

Source files
------------

// File: rtl/pwm_pkg.sv
// pwm_pkg
// Shared definitions for the multi-channel NPC carrier PWM.
//   - dt_state_t : per-channel dead-time FSM encoding
//   - pwm_clog2  : ceil(log2) helper, never returns less than 1
//   - DEF_PERIOD / DEF_DT : default carrier top value and dead time
package pwm_pkg;

  localparam int DEF_PERIOD = 1000;
  localparam int DEF_DT     = 8;

  typedef enum logic [2:0] {
    ST_OFF = 3'd0,  // both gates off, waiting for enable
    ST_D2H = 3'd1,  // dead interval before the high-side gate
    ST_HI  = 3'd2,  // high-side gate on
    ST_D2L = 3'd3,  // dead interval before the low-side gate
    ST_LO  = 3'd4   // low-side gate on
  } dt_state_t;

  // Width needed to hold values 0..value-1. The result is at least 1, so a
  // zero dead time still yields a legal (unused) counter.
  function automatic int pwm_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime
// One channel of complementary gate generation with dead time.
// The raw PWM reference is turned into a high-side and a low-side gate;
// every switch-over passes through a DT-cycle interval with both gates off.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset (gates drop immediately)
//   en    in  run enable; low forces the FSM to OFF
//   raw   in  registered PWM reference for this channel
//   s_hi  out high-side gate (registered)
//   s_lo  out low-side gate (registered)
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT = DEF_DT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic s_hi,
  output logic s_lo
);

  localparam int DTW = pwm_clog2(DT);
  // The dead counter is loaded with DT-1 on entry and the state exits when
  // it reaches zero, giving exactly DT cycles with both gates off.
  localparam logic [DTW-1:0] DT_LOAD = (DT > 0) ? DTW'(DT - 1) : '0;
  localparam bit NO_DEAD = (DT == 0);

  dt_state_t state_reg;
  logic [DTW-1:0] dcnt_reg;

  // Outputs are registered alongside the state so they always decode the
  // state that is being entered; s_hi and s_lo are never set together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_OFF;
      dcnt_reg  <= '0;
      s_hi      <= 1'b0;
      s_lo      <= 1'b0;
    end else if (!en) begin
      state_reg <= ST_OFF;
      dcnt_reg  <= '0;
      s_hi      <= 1'b0;
      s_lo      <= 1'b0;
    end else begin
      case (state_reg)
        ST_OFF, ST_HI, ST_LO: begin
          if (raw && (state_reg != ST_HI)) begin
            // head toward the high side
            if (NO_DEAD) begin
              state_reg <= ST_HI;
              s_hi      <= 1'b1;
              s_lo      <= 1'b0;
            end else begin
              state_reg <= ST_D2H;
              dcnt_reg  <= DT_LOAD;
              s_hi      <= 1'b0;
              s_lo      <= 1'b0;
            end
          end else if (!raw && (state_reg != ST_LO)) begin
            // head toward the low side
            if (NO_DEAD) begin
              state_reg <= ST_LO;
              s_hi      <= 1'b0;
              s_lo      <= 1'b1;
            end else begin
              state_reg <= ST_D2L;
              dcnt_reg  <= DT_LOAD;
              s_hi      <= 1'b0;
              s_lo      <= 1'b0;
            end
          end
        end
        ST_D2H: begin
          if (!raw) begin
            // reference fell during the dead interval: restart toward low
            state_reg <= ST_D2L;
            dcnt_reg  <= DT_LOAD;
          end else if (dcnt_reg == '0) begin
            state_reg <= ST_HI;
            s_hi      <= 1'b1;
            s_lo      <= 1'b0;
          end else begin
            dcnt_reg <= dcnt_reg - DTW'(1);
          end
        end
        ST_D2L: begin
          if (raw) begin
            // reference rose during the dead interval: restart toward high
            state_reg <= ST_D2H;
            dcnt_reg  <= DT_LOAD;
          end else if (dcnt_reg == '0) begin
            state_reg <= ST_LO;
            s_hi      <= 1'b0;
            s_lo      <= 1'b1;
          end else begin
            dcnt_reg <= dcnt_reg - DTW'(1);
          end
        end
        default: begin
          state_reg <= ST_OFF;
          dcnt_reg  <= '0;
          s_hi      <= 1'b0;
          s_lo      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pwm_npc_multi.sv
// pwm_npc_multi
// Multi-channel carrier PWM for the NPC inverter. A single carrier counter
// (sawtooth or triangle) is compared against per-channel shadowed duty
// words; each comparison feeds a dead-time stage producing complementary
// gate signals.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   en    in  run enable; low holds the counter at 0 and turns gates off
//   duty  in  CH*W packed duty words, channel k at [k*W +: W]
//   s_hi  out CH high-side gates
//   s_lo  out CH low-side gates
//   sync  out one-cycle pulse on every cycle where cnt is 0 while running
//   cnt   out current carrier count
module pwm_npc_multi
  import pwm_pkg::*;
#(
  parameter int CH     = 3,
  parameter int W      = 10,
  parameter int PERIOD = DEF_PERIOD,
  parameter int DT     = DEF_DT,
  parameter int CENTER = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CH*W-1:0] duty,
  output logic [CH-1:0] s_hi,
  output logic [CH-1:0] s_lo,
  output logic          sync,
  output logic [W-1:0]  cnt
);

  localparam logic [W-1:0] TOP  = W'(PERIOD);
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic         run_reg;       // en as seen on the previous edge
  logic         dir_down_reg;  // triangle carrier is on its falling slope
  logic [W-1:0] cnt_next;
  logic         dir_down_next;
  logic         load_shadow;

  // Carrier next-state. The first enabled edge (run_reg still low) keeps the
  // count at 0 so the first running cycle starts a fresh period with sync.
  always_comb begin
    cnt_next      = '0;
    dir_down_next = 1'b0;
    if (en && run_reg) begin
      if (CENTER != 0) begin
        if (!dir_down_reg) begin
          if (cnt == TOP) begin
            cnt_next      = LAST;
            dir_down_next = 1'b1;
          end else begin
            cnt_next = cnt + W'(1);
          end
        end else begin
          if (cnt <= W'(1)) begin
            cnt_next      = '0;
            dir_down_next = 1'b0;
          end else begin
            cnt_next      = cnt - W'(1);
            dir_down_next = 1'b1;
          end
        end
      end else begin
        cnt_next = (cnt == LAST) ? '0 : cnt + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      dir_down_reg <= 1'b0;
      run_reg      <= 1'b0;
      sync         <= 1'b0;
    end else begin
      cnt          <= cnt_next;
      dir_down_reg <= dir_down_next;
      run_reg      <= en;
      sync         <= en && (cnt_next == '0);
    end
  end

  // Shadow registers follow duty continuously while stopped, and otherwise
  // only on the edge that returns the carrier to 0.
  assign load_shadow = !en || (cnt_next == '0);

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [W-1:0] duty_in;
      logic [W-1:0] duty_clamped;
      logic [W-1:0] shadow_reg;
      logic         raw_reg;

      assign duty_in      = duty[gi*W +: W];
      assign duty_clamped = (duty_in > TOP) ? TOP : duty_in;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_reg <= '0;
          raw_reg    <= 1'b0;
        end else begin
          if (load_shadow) shadow_reg <= duty_clamped;
          raw_reg <= (shadow_reg > cnt);
        end
      end

      pwm_deadtime #(
        .DT(DT)
      ) u_dt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .raw  (raw_reg),
        .s_hi (s_hi[gi]),
        .s_lo (s_lo[gi])
      );
    end
  endgenerate

endmodule
